// File: rtl/axis_packet_splitter.sv
// axis_packet_splitter: cuts one AXI-Stream packet into consecutive
// per-channel packets, each closed with its own tlast.
module axis_packet_splitter #(
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 16,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
    parameter bit ID_ENABLE   = 1'b0,
    parameter int ID_WIDTH    = ID_ENABLE ? 8 : 1,
    parameter bit DEST_ENABLE = 1'b0,
    parameter int DEST_WIDTH  = DEST_ENABLE ? 8 : 1,
    parameter bit USER_ENABLE = 1'b0,
    parameter int USER_WIDTH  = USER_ENABLE ? 8 : 1,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            operation_start,
    input  logic [CHANNELS-1:0]             use_channels,
    input  logic [CHANNELS*LEN_WIDTH-1:0]   channel_len,
    input  logic                            interrupt,
    output logic                            operation_busy,
    output logic                            operation_complete,
    output logic                            operation_error,
    output logic                            transmission,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [ID_WIDTH-1:0]             s_axis_tid,
    input  logic [DEST_WIDTH-1:0]           s_axis_tdest,
    input  logic [USER_WIDTH-1:0]           s_axis_tuser,
    output logic [CHANNELS*DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [CHANNELS*KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic [CHANNELS-1:0]             m_axis_tvalid,
    input  logic [CHANNELS-1:0]             m_axis_tready,
    output logic [CHANNELS-1:0]             m_axis_tlast,
    output logic [CHANNELS*ID_WIDTH-1:0]    m_axis_tid,
    output logic [CHANNELS*DEST_WIDTH-1:0]  m_axis_tdest,
    output logic [CHANNELS*USER_WIDTH-1:0]  m_axis_tuser
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

    state_t                        state_q, state_d;
    logic [CHANNELS-1:0]           mask_q, mask_d;
    logic [CHANNELS*LEN_WIDTH-1:0] len_q, len_d;
    logic [CW-1:0]                 cur_q, cur_d;
    logic [LEN_WIDTH-1:0]          cnt_q, cnt_d;
    logic                          complete_q, complete_d;
    logic                          transmission_q;

    logic [LEN_WIDTH-1:0]          cur_len;
    logic [CHANNELS-1:0]           cur_bit;
    logic [CHANNELS-1:0]           rest;
    logic                          final_beat;
    logic                          start_ok;
    logic                          unused_fields;

    function automatic logic [CW-1:0] lowest(input logic [CHANNELS-1:0] m);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (m[i]) idx = CW'(i);
        return idx;
    endfunction

    always_comb begin
        start_ok = |use_channels;
        for (int i = 0; i < CHANNELS; i++)
            if (use_channels[i] && channel_len[i*LEN_WIDTH +: LEN_WIDTH] == '0)
                start_ok = 1'b0;
    end

    // The mask loses each channel as it completes, so the remaining
    // bits are exactly the channels still owed a packet.
    assign cur_len    = len_q[int'(cur_q)*LEN_WIDTH +: LEN_WIDTH];
    assign cur_bit    = CHANNELS'(1) << cur_q;
    assign rest       = mask_q & ~cur_bit;
    assign final_beat = (cnt_q == cur_len - LEN_WIDTH'(1));

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        unique case (state_q)
            RUN: begin
                s_axis_tready        = m_axis_tready[cur_q];
                m_axis_tvalid[cur_q] = s_axis_tvalid;
                m_axis_tlast[cur_q]  = final_beat | s_axis_tlast;
            end
            DRAIN:   s_axis_tready = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        len_d      = len_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        complete_d = 1'b0;
        if (interrupt) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (operation_start) begin
                    if (start_ok) begin
                        state_d = RUN;
                        mask_d  = use_channels;
                        len_d   = channel_len;
                        cur_d   = lowest(use_channels);
                        cnt_d   = '0;
                    end else begin
                        state_d = ERR;
                    end
                end
                RUN: if (s_axis_tvalid && m_axis_tready[cur_q]) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (s_axis_tlast) begin
                        if (final_beat && rest == '0) begin
                            state_d    = IDLE;
                            complete_d = 1'b1;
                        end else begin
                            state_d = ERR;
                        end
                    end else if (final_beat) begin
                        if (rest == '0) begin
                            state_d = DRAIN;
                        end else begin
                            mask_d = rest;
                            cur_d  = lowest(rest);
                            cnt_d  = '0;
                        end
                    end
                end
                DRAIN: if (s_axis_tvalid && s_axis_tlast) state_d = ERR;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            len_q          <= '0;
            cur_q          <= '0;
            cnt_q          <= '0;
            complete_q     <= 1'b0;
            transmission_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            len_q          <= len_d;
            cur_q          <= cur_d;
            cnt_q          <= cnt_d;
            complete_q     <= complete_d;
            transmission_q <= |(m_axis_tvalid & m_axis_tready);
        end
    end

    assign operation_busy     = (state_q == RUN) || (state_q == DRAIN);
    assign operation_error    = (state_q == ERR);
    assign operation_complete = complete_q;
    assign transmission       = transmission_q;

    // Sideband fields are broadcast; only the current channel sees tvalid.
    assign m_axis_tdata = {CHANNELS{s_axis_tdata}};
    assign m_axis_tkeep = KEEP_ENABLE ? {CHANNELS{s_axis_tkeep}} : '1;
    assign m_axis_tid   = ID_ENABLE   ? {CHANNELS{s_axis_tid}}   : '0;
    assign m_axis_tdest = DEST_ENABLE ? {CHANNELS{s_axis_tdest}} : '0;
    assign m_axis_tuser = USER_ENABLE ? {CHANNELS{s_axis_tuser}} : '0;

    assign unused_fields = ^{s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser};

endmodule

// File: tb/tb_axis_packet_splitter.sv
// Bench for axis_packet_splitter: random packets and channel plans
// checked against a queue model of the splitting rules.
module tb_axis_packet_splitter;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int KW = 2;
    localparam int LW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             operation_start = 1'b0;
    logic [CH-1:0]    use_channels = '0;
    logic [CH*LW-1:0] channel_len = '0;
    logic             interrupt = 1'b0;
    logic             operation_busy, operation_complete;
    logic             operation_error, transmission;
    logic [DW-1:0]    s_axis_tdata = '0;
    logic [KW-1:0]    s_axis_tkeep = '1;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic             s_axis_tlast = 1'b0;
    logic [0:0]       s_axis_tid = '0;
    logic [0:0]       s_axis_tdest = '0;
    logic [0:0]       s_axis_tuser = '0;
    logic [CH*DW-1:0] m_axis_tdata;
    logic [CH*KW-1:0] m_axis_tkeep;
    logic [CH-1:0]    m_axis_tvalid;
    logic [CH-1:0]    m_axis_tready = '1;
    logic [CH-1:0]    m_axis_tlast;
    logic [CH-1:0]    m_axis_tid, m_axis_tdest, m_axis_tuser;

    always #5 clk = ~clk;

    axis_packet_splitter #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .operation_start(operation_start),
        .use_channels(use_channels),
        .channel_len(channel_len),
        .interrupt(interrupt),
        .operation_busy(operation_busy),
        .operation_complete(operation_complete),
        .operation_error(operation_error),
        .transmission(transmission),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] pkt[$];
    int            sent;
    logic [DW:0]   exp_q[CH][$];
    logic [DW:0]   got_q[CH][$];
    bit            exp_ok_start;
    bit            exp_complete;
    int            n_complete, n_error;
    bit            prev_hs = 1'b0;
    bit            chk_tx = 1'b1;

    always @(negedge clk) begin
        bit any_hs;
        any_hs = 1'b0;
        for (int c = 0; c < CH; c++)
            if (m_axis_tvalid[c] && m_axis_tready[c]) begin
                got_q[c].push_back({m_axis_tlast[c], m_axis_tdata[c*DW +: DW]});
                any_hs = 1'b1;
            end
        if (operation_complete) n_complete++;
        if (operation_error) n_error++;
        if (chk_tx) check("transmission", 32'(transmission), 32'(prev_hs));
        prev_hs = any_hs;
    end

    // Channels in ascending order take len beats each from the input;
    // the op completes only if input ends exactly with the last channel.
    task automatic build_model(input logic [CH-1:0] mask,
                               input logic [CH*LW-1:0] lens);
        int pos;
        int len;
        bit filled;
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        exp_complete = 1'b0;
        exp_ok_start = (mask != '0);
        for (int c = 0; c < CH; c++)
            if (mask[c] && lens[c*LW +: LW] == '0) exp_ok_start = 1'b0;
        if (!exp_ok_start) return;
        pos = 0;
        filled = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (!mask[c]) continue;
            if (pos >= pkt.size()) begin
                filled = 1'b0;
                break;
            end
            len = int'(lens[c*LW +: LW]);
            for (int k = 0; k < len; k++) begin
                if (pos >= pkt.size()) begin
                    filled = 1'b0;
                    break;
                end
                exp_q[c].push_back({(k == len - 1) || (pos == pkt.size() - 1),
                                    pkt[pos]});
                pos++;
            end
        end
        exp_complete = filled && (pos == pkt.size());
    endtask

    task automatic drive_beats(input int cnt, input bit bp);
        int done;
        int cyc;
        bit hs;
        done = 0;
        cyc = 0;
        while (done < cnt && cyc < 500) begin
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata  = pkt[sent];
            s_axis_tlast  = (sent == pkt.size() - 1);
            for (int c = 0; c < CH; c++)
                m_axis_tready[c] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            operation_start = ($urandom_range(0, 7) == 0);
            use_channels    = CH'($urandom);
            channel_len     = (CH*LW)'({$urandom, $urandom});
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                sent++;
                done++;
            end
            cyc++;
        end
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        operation_start = 1'b0;
        if (done < cnt) check("drive_timeout", 32'(done), 32'(cnt));
    endtask

    task automatic start_op(input logic [CH-1:0] mask,
                            input logic [CH*LW-1:0] lens, input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(DW'($urandom));
        sent = 0;
        for (int c = 0; c < CH; c++) got_q[c].delete();
        n_complete = 0;
        n_error = 0;
        operation_start = 1'b1;
        use_channels    = mask;
        channel_len     = lens;
        @(posedge clk);
        #1;
        operation_start = 1'b0;
        use_channels    = CH'($urandom);
        channel_len     = (CH*LW)'({$urandom, $urandom});
    endtask

    task automatic run_op(input string tag, input logic [CH-1:0] mask,
                          input logic [CH*LW-1:0] lens, input int n,
                          input bit bp);
        int m;
        start_op(mask, lens, n);
        build_model(mask, lens);
        @(negedge clk);
        check({tag, ":busy"}, 32'(operation_busy), 32'(exp_ok_start));
        check({tag, ":early_err"}, 32'(operation_error), 32'(!exp_ok_start));
        @(posedge clk);
        #1;
        if (exp_ok_start) drive_beats(n, bp);
        repeat (4) @(posedge clk);
        #1;
        check({tag, ":complete"}, 32'(n_complete), 32'(exp_complete));
        check({tag, ":error"}, 32'(n_error), 32'(!exp_complete));
        check({tag, ":idle"}, 32'(operation_busy), 32'(0));
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s:ch%0d_beats", tag, c),
                  32'(got_q[c].size()), 32'(exp_q[c].size()));
            m = (got_q[c].size() < exp_q[c].size()) ? got_q[c].size()
                                                    : exp_q[c].size();
            for (int k = 0; k < m; k++)
                check($sformatf("%s:ch%0d_b%0d", tag, c, k),
                      32'(got_q[c][k]), 32'(exp_q[c][k]));
        end
    endtask

    initial begin
        logic [CH-1:0]    rmask;
        logic [CH*LW-1:0] rlens;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(operation_busy), 32'(0));
        check("rst_complete", 32'(operation_complete), 32'(0));
        check("rst_error", 32'(operation_error), 32'(0));
        check("rst_tx", 32'(transmission), 32'(0));
        check("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("rst_tready", 32'(s_axis_tready), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("basic", 2'b11, {16'd3, 16'd2}, 5, 1'b0);
        run_op("mask10", 2'b10, {16'd4, 16'd0}, 4, 1'b0);
        run_op("bp", 2'b11, {16'd3, 16'd2}, 5, 1'b1);
        run_op("long", 2'b11, {16'd2, 16'd2}, 6, 1'b1);
        run_op("short", 2'b11, {16'd2, 16'd2}, 3, 1'b0);
        run_op("mask0", 2'b00, {16'd2, 16'd2}, 1, 1'b0);
        run_op("len0", 2'b11, {16'd2, 16'd0}, 1, 1'b0);

        // interrupt mid channel 0: abandoned without tlast
        start_op(2'b11, {16'd3, 16'd3}, 6);
        drive_beats(2, 1'b0);
        interrupt = 1'b1;
        @(posedge clk);
        #1;
        interrupt = 1'b0;
        @(negedge clk);
        check("irq_busy", 32'(operation_busy), 32'(0));
        check("irq_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("irq_ch0_beats", 32'(got_q[0].size()), 32'(2));
        if (got_q[0].size() >= 2) begin
            check("irq_b0", 32'(got_q[0][0]), 32'({1'b0, pkt[0]}));
            check("irq_b1", 32'(got_q[0][1]), 32'({1'b0, pkt[1]}));
        end
        repeat (3) @(posedge clk);
        #1;
        check("irq_complete", 32'(n_complete), 32'(0));
        check("irq_error", 32'(n_error), 32'(0));
        run_op("after_irq", 2'b11, {16'd2, 16'd1}, 3, 1'b1);

        // asynchronous reset mid RUN with a beat in flight
        start_op(2'b11, {16'd2, 16'd2}, 4);
        drive_beats(1, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pkt[1];
        chk_tx = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(operation_busy), 32'(0));
        check("arst_complete", 32'(operation_complete), 32'(0));
        check("arst_error", 32'(operation_error), 32'(0));
        check("arst_tx", 32'(transmission), 32'(0));
        check("arst_tvalid", 32'(m_axis_tvalid), 32'(0));
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_tx = 1'b1;
        check("arst_n_complete", 32'(n_complete), 32'(0));
        check("arst_n_error", 32'(n_error), 32'(0));
        run_op("after_rst", 2'b11, {16'd3, 16'd2}, 5, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rmask = (t % 10 == 9) ? 2'b00 : CH'($urandom_range(1, 3));
            for (int c = 0; c < CH; c++)
                rlens[c*LW +: LW] = ($urandom_range(0, 15) == 0)
                                    ? LW'(0) : LW'($urandom_range(1, 4));
            run_op($sformatf("rnd%0d", t), rmask, rlens,
                   $urandom_range(1, 10), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_packet_splitter.md
Name: axis_packet_splitter

Overview:
- Splits one input AXI-Stream packet into consecutive output packets, one per selected channel, with a programmed beat count per channel.
- Each output packet carries its own tlast.
- Sits upstream of the packet joiner: it fans one stream out to parallel per-channel processing lanes, and the joiner re-concatenates their results.
- Control and status handshake matches the joiner: operation_start, use_channels, and busy/complete/error pulses.

Parameters:
CHANNELS, 2, number of output channels (>=2)
DATA_WIDTH, 16, tdata width in bits
KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep
KEEP_WIDTH, (DATA_WIDTH+7)/8 if KEEP_ENABLE else 1, tkeep width
ID_ENABLE / ID_WIDTH, 0 / 8 if enabled else 1, tid propagation and width
DEST_ENABLE / DEST_WIDTH, 0 / 8 if enabled else 1, tdest propagation and width
USER_ENABLE / USER_WIDTH, 0 / 8 if enabled else 1, tuser propagation and width
LEN_WIDTH, 16, width of per-channel beat count

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
operation_start  in  1  start request, sampled only in IDLE
use_channels  in  CHANNELS  channel select mask, latched at start
channel_len  in  CHANNELS*LEN_WIDTH  beats per channel, LSB slice = channel 0, latched at start
interrupt  in  1  synchronous abort
operation_busy  out  1  high while splitting
operation_complete  out  1  one-cycle pulse on clean finish
operation_error  out  1  one-cycle pulse on any error
transmission  out  1  registered: high if any output handshake occurred the previous cycle
s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in/out  single-channel widths  input stream
m_axis_tdata/tkeep/tid/tdest/tuser  out  CHANNELS*field width  per-channel output fields
m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  CHANNELS  per-channel handshake

Behaviour:
- Reset (async): state IDLE; busy, complete, error and transmission are 0; all latched registers are 0.
- FSM states: IDLE, RUN, DRAIN, ERR.
- IDLE: s_axis_tready=0 and all m_axis_tvalid=0.
  - operation_start with use_channels!=0 and every selected channel_len!=0: latch mask and lengths, current channel = lowest selected bit, beat counter = 0, go to RUN.
  - operation_start with mask==0, or any selected length==0: go to ERR.
- RUN: zero-latency combinational pass-through to channel cur.
  - m_axis_tvalid[cur]=s_axis_tvalid; s_axis_tready=m_axis_tready[cur]; other tvalid bits = 0.
  - Data, keep, id, dest and user fields are broadcast on every channel slice.
  - On handshake, the counter increments.
  - m_axis_tlast[cur]=1 when counter==len[cur]-1 or s_axis_tlast=1; otherwise 0.
  - Channel-final beat, not last selected channel, s_axis_tlast=0: clear cur from the mask, counter=0, cur = next higher selected bit.
  - Channel-final beat of last selected channel with s_axis_tlast=1: go to IDLE; operation_complete pulses the next cycle.
  - Channel-final beat of last selected channel with s_axis_tlast=0: go to DRAIN.
  - s_axis_tlast=1 before the last selected channel's final beat (short input): the current output packet closes with tlast; go to ERR. Remaining channels get no packet.
- DRAIN: s_axis_tready=1 and all m_axis_tvalid=0, so input beats are discarded. On a handshake with s_axis_tlast=1, go to ERR.
- ERR: one cycle with operation_error=1, then IDLE.
- operation_busy=1 in RUN and DRAIN. It rises the cycle after start is accepted and falls on the same edge that complete or error rises.
- operation_start outside IDLE is ignored.
- interrupt: next edge goes to IDLE with no complete or error pulse. Any partially sent output packet is abandoned without tlast. interrupt has priority over all other transitions.
- Counter is LEN_WIDTH bits and never wraps, because the channel advances at len-1.
- transmission <= |(m_axis_tvalid & m_axis_tready).

Test Plan:
- CHANNELS=2, mask=2'b11, len={3,2}, 5-beat input D0..D4 with tlast on D4, all tready=1: ch0 gets D0,D1 with tlast on D1; ch1 gets D2..D4 with tlast on D4; complete pulses once; error stays 0.
- mask=2'b10, len1=4, 4-beat input: ch0 tvalid stays 0 throughout; ch1 receives all 4 beats with tlast on beat 3; complete=1.
- Backpressure: same as test 1, with ch1 tready toggling every cycle: no beat lost or duplicated; s_axis_tready mirrors m_axis_tready[1] while ch1 is current; transmission high only the cycle after each handshake.
- Long input: len={2,2}, 6-beat input: 4 beats delivered; DRAIN swallows 2 beats; error pulses after the input tlast; complete=0.
- Short input and bad start:
  - 3-beat input with len={2,2}: ch1 gets 1 beat with tlast; error=1.
  - Start with mask=0: error pulses 1 cycle after start; busy stays 0.
- interrupt asserted mid-ch0 and async rst asserted mid-RUN: both return to IDLE; busy, complete and error are 0; a new start then splits correctly.
